// File: rtl/vpp_vertex_scheduler.sv
// Vertex scheduler for one vertex_post_processor (VPP) instance.
// Walks a batch of clip-space vertices: reads each one from the clip-space
// RAM, hands it to the VPP, and stores the pixel-space result plus its
// invalid flag in the screen-space RAM at the same index. Reports batch
// completion and how many vertices the VPP rejected.
//
// VPP handshake: o_vpp_vertex_dv is only raised while i_vpp_ready is high,
// so every dv cycle is a transfer. dv lasts exactly one cycle per vertex, and
// the next vertex is not offered until i_vpp_done has returned for the
// current one. o_vpp_vertex stays constant from LATCH until the next LATCH.
module vpp_vertex_scheduler #(
   parameter int IV_DATAWIDTH = 24,
   parameter int OV_DATAWIDTH = 12,
   parameter int ADDR_WIDTH   = 8
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             start,
   input  logic [ADDR_WIDTH:0]              num_vertices,
   output logic                             busy,
   output logic                             finished,
   output logic [ADDR_WIDTH:0]              invalid_count,
   output logic [ADDR_WIDTH-1:0]            o_vmem_addr,
   input  logic signed [4*IV_DATAWIDTH-1:0] i_vmem_data,
   output logic signed [4*IV_DATAWIDTH-1:0] o_vpp_vertex,
   output logic                             o_vpp_vertex_dv,
   input  logic                             i_vpp_ready,
   input  logic signed [3*OV_DATAWIDTH-1:0] i_vpp_vertex_pixel,
   input  logic                             i_vpp_done,
   input  logic                             i_vpp_invalid,
   output logic [ADDR_WIDTH-1:0]            o_ssmem_addr,
   output logic                             o_ssmem_we,
   output logic signed [3*OV_DATAWIDTH-1:0] o_ssmem_data,
   output logic                             o_ssmem_invalid,
   output logic [2:0]                       state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LATCH = 3'd2,
      S_ISSUE = 3'd3,
      S_WAIT  = 3'd4,
      S_WRITE = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t              state;
   state_t              state_next;
   // idx carries one extra bit so a full 2^ADDR_WIDTH batch ends without wrap.
   logic [ADDR_WIDTH:0] idx;
   logic [ADDR_WIDTH:0] n_lat;
   logic [ADDR_WIDTH:0] idx_inc;

   assign idx_inc   = idx + 1'b1;
   assign state_dbg = state;

   // State register; synchronous active-low reset drops any batch in flight.
   always_ff @(posedge clk) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state selection and the state-decoded control outputs.
   always_comb begin
      state_next      = state;
      busy            = (state != S_IDLE);
      finished        = 1'b0;
      o_vpp_vertex_dv = 1'b0;
      o_ssmem_we      = 1'b0;
      o_vmem_addr     = idx[ADDR_WIDTH-1:0];
      case (state)
         S_IDLE: begin
            if (start) begin
               if (num_vertices == '0) state_next = S_DONE;
               else                    state_next = S_FETCH;
            end
         end
         S_FETCH: state_next = S_LATCH;
         S_LATCH: state_next = S_ISSUE;
         S_ISSUE: begin
            if (i_vpp_ready) begin
               o_vpp_vertex_dv = 1'b1;
               state_next      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_vpp_done) state_next = S_WRITE;
         end
         S_WRITE: begin
            o_ssmem_we = 1'b1;
            if (idx_inc == n_lat) state_next = S_DONE;
            else                  state_next = S_FETCH;
         end
         S_DONE: begin
            finished   = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Batch bookkeeping, vertex capture and result capture.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         idx             <= '0;
         n_lat           <= '0;
         invalid_count   <= '0;
         o_vpp_vertex    <= '0;
         o_ssmem_addr    <= '0;
         o_ssmem_data    <= '0;
         o_ssmem_invalid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_lat         <= num_vertices;
                  idx           <= '0;
                  invalid_count <= '0;
               end
            end
            S_LATCH: o_vpp_vertex <= i_vmem_data;
            S_WAIT: begin
               if (i_vpp_done) begin
                  o_ssmem_data    <= i_vpp_vertex_pixel;
                  o_ssmem_invalid <= i_vpp_invalid;
                  o_ssmem_addr    <= idx[ADDR_WIDTH-1:0];
               end
            end
            S_WRITE: begin
               idx <= idx_inc;
               if (o_ssmem_invalid) invalid_count <= invalid_count + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vpp_vertex_scheduler.sv
// Bench for vpp_vertex_scheduler: a clip-space RAM model, a behavioural VPP
// with random latency, and a scoreboard of expected VPP issues and
// screen-space writes built from the vertex contents of each batch.
module tb_vpp_vertex_scheduler;
   localparam int IVW = 24;
   localparam int OVW = 12;
   localparam int AW  = 8;
   localparam logic [2:0] ST_ISSUE = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               start = 1'b0;
   logic [AW:0]        num_vertices = '0;
   logic               busy, finished;
   logic [AW:0]        invalid_count;
   logic [AW-1:0]      o_vmem_addr;
   logic [4*IVW-1:0]   i_vmem_data = '0;
   logic [4*IVW-1:0]   o_vpp_vertex;
   logic               o_vpp_vertex_dv;
   logic               i_vpp_ready;
   logic [3*OVW-1:0]   i_vpp_vertex_pixel = '0;
   logic               i_vpp_done = 1'b0;
   logic               i_vpp_invalid = 1'b0;
   logic [AW-1:0]      o_ssmem_addr;
   logic               o_ssmem_we;
   logic [3*OVW-1:0]   o_ssmem_data;
   logic               o_ssmem_invalid;
   logic [2:0]         state_dbg;

   int checks = 0;
   int errors = 0;
   int dv_cnt = 0;
   int wr_cnt = 0;

   logic [4*IVW-1:0]   vmem [0:(1<<AW)-1];
   logic [4*IVW-1:0]   exp_vtx_q [$];
   logic [AW+3*OVW:0]  exp_q [$];

   logic               vpp_busy = 1'b0;
   int                 vpp_cnt = 0;
   logic [4*IVW-1:0]   vpp_vtx = '0;
   logic               hold_ready = 1'b0;

   vpp_vertex_scheduler #(.IV_DATAWIDTH(IVW), .OV_DATAWIDTH(OVW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .num_vertices(num_vertices),
      .busy(busy), .finished(finished), .invalid_count(invalid_count),
      .o_vmem_addr(o_vmem_addr), .i_vmem_data(i_vmem_data),
      .o_vpp_vertex(o_vpp_vertex), .o_vpp_vertex_dv(o_vpp_vertex_dv),
      .i_vpp_ready(i_vpp_ready), .i_vpp_vertex_pixel(i_vpp_vertex_pixel),
      .i_vpp_done(i_vpp_done), .i_vpp_invalid(i_vpp_invalid),
      .o_ssmem_addr(o_ssmem_addr), .o_ssmem_we(o_ssmem_we),
      .o_ssmem_data(o_ssmem_data), .o_ssmem_invalid(o_ssmem_invalid),
      .state_dbg(state_dbg)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // Behavioural VPP: invalid when z <= 0, otherwise a fixed projection of fields.
   function automatic logic [3*OVW:0] vpp_fn(input logic [4*IVW-1:0] v);
      logic signed [IVW-1:0] z;
      z = v[2*IVW-1:IVW];
      vpp_fn = {(z <= 0), v[4*IVW-1 -: OVW], v[3*IVW-1 -: OVW], v[2*IVW-1 -: OVW] ^ v[OVW-1:0]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Clip-space RAM with a one-cycle registered read.
   always @(posedge clk) i_vmem_data <= vmem[o_vmem_addr];

   assign i_vpp_ready = !vpp_busy && !i_vpp_done && !hold_ready;

   // VPP model: accepts on dv, answers with done after 1..4 cycles.
   always @(posedge clk) begin
      i_vpp_done <= 1'b0;
      if (!rstn) begin
         vpp_busy <= 1'b0;
         vpp_cnt  <= 0;
      end else if (vpp_busy) begin
         if (vpp_cnt == 0) begin
            vpp_busy <= 1'b0;
            i_vpp_done <= 1'b1;
            {i_vpp_invalid, i_vpp_vertex_pixel} <= vpp_fn(vpp_vtx);
         end else begin
            vpp_cnt <= vpp_cnt - 1;
         end
      end else if (o_vpp_vertex_dv && i_vpp_ready) begin
         vpp_busy <= 1'b1;
         vpp_vtx  <= o_vpp_vertex;
         vpp_cnt  <= int'($urandom_range(0, 3));
      end
   end

   // Scoreboard: every issue and every write is matched in order.
   always @(negedge clk) begin
      #3;
      if (rstn && o_vpp_vertex_dv) begin
         chk("dv_with_ready", i_vpp_ready, 1'b1);
         chk("dv_prev_written", dv_cnt - wr_cnt, 0);
         chk("dv_expected_pending", exp_vtx_q.size() > 0, 1'b1);
         if (exp_vtx_q.size() > 0) chk("dv_vertex", o_vpp_vertex, exp_vtx_q.pop_front());
         dv_cnt++;
      end
      if (rstn && o_ssmem_we) begin
         chk("wr_expected_pending", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0)
            chk("wr_entry", {o_ssmem_invalid, o_ssmem_addr, o_ssmem_data}, exp_q.pop_front());
         wr_cnt++;
      end
   end

   // pat: 0 all valid, 1 odd indices invalid, 2 random
   task automatic start_batch(input int n, input int pat, output int inv);
      logic [IVW-1:0] z;
      logic [3*OVW:0] r;
      inv = 0;
      dv_cnt = 0;
      wr_cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (pat == 0 || (pat == 1 && (i % 2) == 0) || (pat == 2 && $urandom_range(0, 2) != 0))
            z = IVW'($urandom_range(1, 4000000));
         else
            z = IVW'(0 - $urandom_range(0, 5000));
         vmem[i] = {IVW'($urandom), IVW'($urandom), z, IVW'($urandom)};
         r = vpp_fn(vmem[i]);
         exp_vtx_q.push_back(vmem[i]);
         exp_q.push_back({r[3*OVW], AW'(i), r[3*OVW-1:0]});
         if (r[3*OVW]) inv++;
      end
      start = 1'b1;
      num_vertices = (AW+1)'(n);
      @(negedge clk);
      start = 1'b0;
      num_vertices = (AW+1)'($urandom);
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic finish_batch(input int n, input int inv, input bit restart, input bit start_in_done);
      int cyc = 0;
      while (!finished && cyc < 20000) begin
         if (restart && cyc == 15) begin
            start = 1'b1;
            num_vertices = 9'd7;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("finished_seen", finished, 1'b1);
      if (n == 0) chk("zero_batch_finish_latency", cyc, 0);
      if (start_in_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("finished_one_cycle", finished, 1'b0);
      chk("busy_low_after_done", busy, 1'b0);
      chk("invalid_count", invalid_count, inv);
      chk("dv_count", dv_cnt, n);
      chk("write_count", wr_cnt, n);
      chk("vtx_queue_empty", exp_vtx_q.size(), 0);
      chk("wr_queue_empty", exp_q.size(), 0);
      if (start_in_done) begin
         @(negedge clk);
         chk("start_in_done_ignored", busy, 1'b0);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_finished"}, finished, 1'b0);
      chk({tag, "_dv"}, o_vpp_vertex_dv, 1'b0);
      chk({tag, "_we"}, o_ssmem_we, 1'b0);
      chk({tag, "_inv_cnt"}, invalid_count, 0);
      chk({tag, "_vmem_addr"}, o_vmem_addr, 0);
      chk({tag, "_ss_addr"}, o_ssmem_addr, 0);
      chk({tag, "_ss_data"}, {o_ssmem_invalid, o_ssmem_data}, 0);
      chk({tag, "_vertex"}, o_vpp_vertex, 0);
   endtask

   initial begin
      int inv;
      int cyc;
      logic [4*IVW-1:0] held;

      // reset
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rstn = 1'b1;
      @(negedge clk);

      // N=3, all valid; start offered in the DONE cycle must be ignored
      start_batch(3, 0, inv);
      finish_batch(3, inv, 1'b0, 1'b1);

      // N=4, vertices 1 and 3 invalid
      start_batch(4, 1, inv);
      chk("odd_invalid_expected", inv, 2);
      finish_batch(4, inv, 1'b0, 1'b0);

      // N=0: straight to DONE, nothing issued or written
      start_batch(0, 0, inv);
      finish_batch(0, 0, 1'b0, 1'b0);

      // VPP not ready for 10 cycles while a vertex waits in ISSUE
      hold_ready = 1'b1;
      start_batch(2, 2, inv);
      cyc = 0;
      while (state_dbg != ST_ISSUE && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("reached_issue", state_dbg, ST_ISSUE);
      held = o_vpp_vertex;
      chk("held_vertex_is_v0", held, vmem[0]);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_no_dv", o_vpp_vertex_dv, 1'b0);
         chk("hold_vertex_stable", o_vpp_vertex, held);
      end
      hold_ready = 1'b0;
      #1;
      chk("dv_on_ready_rise", o_vpp_vertex_dv, 1'b1);
      finish_batch(2, inv, 1'b0, 1'b0);

      // N=5 with a second start (different length) mid-batch
      start_batch(5, 2, inv);
      finish_batch(5, inv, 1'b1, 1'b0);

      // reset while waiting on the VPP for vertex 2, then a clean N=2 batch
      start_batch(4, 2, inv);
      cyc = 0;
      while (dv_cnt < 2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("in_wait_vertex2", state_dbg, ST_WAIT);
      rstn = 1'b0;
      @(negedge clk);
      check_reset_values("midreset");
      exp_q.delete();
      exp_vtx_q.delete();
      rstn = 1'b1;
      @(negedge clk);
      chk("no_write_after_reset", wr_cnt, 1);
      start_batch(2, 2, inv);
      finish_batch(2, inv, 1'b0, 1'b0);

      // full address space batch
      start_batch(1 << AW, 2, inv);
      finish_batch(1 << AW, inv, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
